// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divider-chain rate monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NUM_CH = 5;

  localparam logic [2:0] CH_DIV2  = 3'd0;
  localparam logic [2:0] CH_DIV4  = 3'd1;
  localparam logic [2:0] CH_DIV8  = 3'd2;
  localparam logic [2:0] CH_DIV16 = 3'd3;
  localparam logic [2:0] CH_Y     = 3'd4;

  // Ideal rising-edge count of a channel over a gate window; Y = div2&div8
  // produces two rising edges per div8 period, i.e. the div4 rate.
  function automatic int expected_count(input logic [2:0] ch, input int gate);
    case (ch)
      CH_DIV2:  return gate / 2;
      CH_DIV4:  return gate / 4;
      CH_DIV8:  return gate / 8;
      CH_DIV16: return gate / 16;
      CH_Y:     return gate / 4;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/div_mon_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one divider tap.
module div_mon_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/div_mon.sv
// Rate monitor for the ripple divider: counts edges of one tap over a gate window.
// Optional feature macro: DIV_MON_EXPECT_CHECK_EN (ideal-ratio compare + sticky error).
module div_mon
  import div_mon_pkg::*;
#(
  parameter int GATE_CYCLES = 256,
  parameter int CNT_W       = 9,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       div_in,
  input  logic [2:0]       sel,
  input  logic             start,
  input  logic             clr_err,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] result,
  output logic             mismatch,
  output logic             err_sticky
);

  localparam int TW = $clog2(GATE_CYCLES);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] count, count_nxt;
  logic [NUM_CH-1:0] edge_det;
  logic [7:0]       edge_ext;
  logic             edge_sel;
  logic             gate_last;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    div_mon_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (div_in[i]),
      .pulse (edge_det[i])
    );
  end

  // Selects 5-7 map onto the zero-extended bits, so counting is disabled there.
  assign edge_ext  = {{(8-NUM_CH){1'b0}}, edge_det};
  assign edge_sel  = edge_ext[sel_q];
  assign gate_last = (state == GATE) && (timer == TW'(GATE_CYCLES - 1));

  always_comb begin
    count_nxt = count;
    if (edge_sel && (count != '1)) count_nxt = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      sel_q        <= '0;
      count        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            sel_q <= sel;
            count <= '0;
            timer <= '0;
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          // Two settle cycles before the gate opens.
          if (timer == TW'(1)) begin
            timer <= '0;
            state <= GATE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GATE: begin
          count <= count_nxt;
          timer <= timer + 1'b1;
          if (gate_last) begin
            // Include a pulse seen on the final gate cycle.
            result       <= count_nxt;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_MON_EXPECT_CHECK_EN
  logic [CNT_W:0] exp_cnt, res_ext, diff;
  logic           mm_nxt;

  always_comb begin
    exp_cnt = (CNT_W+1)'(expected_count(sel_q, GATE_CYCLES));
    res_ext = {1'b0, count_nxt};
    diff    = (res_ext >= exp_cnt) ? (res_ext - exp_cnt) : (exp_cnt - res_ext);
    mm_nxt  = (sel_q > CH_Y) || (diff > (CNT_W+1)'(TOL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (gate_last) mismatch <= mm_nxt;
      // Set after clear so a coincident mismatch wins.
      if (clr_err) err_sticky <= 1'b0;
      if ((state == DONE) && mismatch) err_sticky <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = clr_err ^ (TOL != 0);
  assign mismatch   = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: doc/div_mon.md
# div_mon

Synchronous monitor downstream of the ripple clock divider (div2/div4/div8/div16 and the div2&div8 product Y). Samples the divided signals in the `clk` domain, counts rising edges of one selected channel over a fixed gate window, publishes the count, and flags mismatch against the ideal ratio. Gives firmware and test benches a cycle-exact check that the divider chain toggles at the right rate after reset.

## Interface
Parameters:
- GATE_CYCLES, 256: gate window length in `clk` cycles; power of two, ≥32.
- CNT_W, 9: edge counter and result width; must hold GATE_CYCLES/2 + 1.
- TOL, 1: allowed |result − expected| before mismatch.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- div_in  in  5  [0]=div2, [1]=div4, [2]=div8, [3]=div16, [4]=Y; asynchronous relative to clk.
- sel  in  3  channel select; sampled only when start is accepted.
- start  in  1  one-cycle request; accepted only in IDLE.
- clr_err  in  1  clears err_sticky.
- busy  out  1  high from ARM through DONE.
- result_valid  out  1  one-cycle pulse in DONE.
- result  out  CNT_W  edge count of last window; held until next DONE.
- mismatch  out  1  compare outcome of last window; held until next DONE.
- err_sticky  out  1  set on any mismatch; held until clr_err.

## Operation
- Each div_in bit: 2-flop synchronizer, then rising-edge detect (sync output high, previous low).
- FSM: IDLE → (start) ARM → (2 cycles) GATE → (GATE_CYCLES cycles) DONE → (1 cycle) IDLE.
- On start acceptance: latch sel; clear edge counter.
- GATE: count +1 in each cycle the selected edge detector fires; saturate at all-ones.
- DONE: result <= count, result_valid = 1, mismatch computed.
- Expected count: div2 GATE/2, div4 GATE/4, div8 GATE/8, div16 GATE/16, Y GATE/4.
- mismatch = |result − expected| > TOL, unsigned compare in CNT_W+1 bits.
- sel 5–7: counting disabled, result = 0, mismatch = 1.
- start outside IDLE: ignored, no queueing.
- err_sticky: set in DONE when mismatch; clr_err clears; set and clear in same cycle → set wins.
- reset: FSM to IDLE, synchronizers, counter, all outputs to 0; aborts any window, no result_valid.

## Timing
- start sampled at cycle 0; busy high cycles 1 to GATE_CYCLES+3; ARM cycles 1–2; GATE cycles 3 to GATE_CYCLES+2; DONE/result_valid at cycle GATE_CYCLES+3; busy low at cycle GATE_CYCLES+4.
- A start in the first IDLE cycle after DONE is accepted (back-to-back windows, one idle cycle between).
- div_in edge to detector pulse: 2–3 cycles (synchronizer + compare). Edges on the final GATE cycle count.
- All outputs registered; reset values all 0.

## Configuration
- DIV_MON_EXPECT_CHECK_EN defined: expected-count compare, mismatch, err_sticky, clr_err logic present.
- Undefined: compare logic removed; mismatch and err_sticky tied 0; clr_err ignored; result/result_valid unchanged.

## Structure
- Package div_mon_pkg: FSM state enum (IDLE, ARM, GATE, DONE), channel index constants, function returning expected count from channel and GATE_CYCLES.
- Sub-module div_mon_sync_edge: 2-flop synchronizer + rising-edge detector, synchronous reset, instantiated once per div_in bit.

## Test plan
- Ideal divider model driving div_in, sel=0, start → result_valid at cycle 259, result=128, mismatch=0.
- sel=3 (div16) ideal → result=16, mismatch=0; sel=4 (Y) → result=64.
- div4 stuck low, sel=1 → result=0, mismatch=1, err_sticky=1; clr_err pulse → err_sticky=0; clr_err concurrent with DONE mismatch → err_sticky stays 1.
- sel=6 → result=0, mismatch=1; start pulses during busy → ignored, exactly one result_valid.
- reset asserted mid-GATE → next cycle busy=0, all outputs 0, no result_valid; new start completes normally.
- Macro undefined, faulty channel → result correct, mismatch=0, err_sticky=0.
